// File: rtl/tetris_ctrl_gen.sv
// tetris_ctrl_gen: game-flow controller for a falling-block game.
// Sequences spawn / move / drop / line-removal strobes toward the datapath,
// runs the level-dependent auto-drop timer, and turns raw key levels into
// edge + auto-repeat events.
module tetris_ctrl_gen #(
    parameter int BASE_PERIOD     = 25000000,
    parameter int PERIOD_STEP     = 2000000,
    parameter int MIN_PERIOD      = 2500000,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15,
    parameter int RPT_DELAY       = 8000000,
    parameter int RPT_RATE        = 2000000,
    localparam int LW             = $clog2(MAX_LEVEL + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          pause,
    input  logic          rotate,
    input  logic          left,
    input  logic          right,
    input  logic          down,
    input  logic          move_comp,
    input  logic          down_comp,
    input  logic          remove_finish,
    input  logic [2:0]    lines_cleared,
    input  logic          die,
    output logic [3:0]    opcode,
    output logic          gen_random,
    output logic          keep,
    output logic          move,
    output logic          renew1,
    output logic          move_down,
    output logic          renew2,
    output logic          remove,
    output logic          new_piece,
    output logic          stop,
    output logic          auto_down,
    output logic          paused,
    output logic [LW-1:0] level
);

    // Timer must hold the larger of the base period and the floor.
    localparam int PMAX = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
    localparam int TW   = $clog2(PMAX + 1);
    localparam int TW1  = TW + 1;
    // Repeat counter sized for the longer of the two repeat intervals.
    localparam int RMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int CW   = $clog2(RMAX + 1);
    // Line counter holds at most LINES_PER_LEVEL-1 plus four new lines.
    localparam int LCW  = $clog2(LINES_PER_LEVEL + 5);

    typedef enum logic [3:0] {
        S_BLANK, S_RANDOM, S_KEEP, S_MOVE, S_RENEW1, S_DOWN,
        S_RENEW2, S_REMOVE, S_NEW, S_STOP, S_PAUSE
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       opcode_nxt;
    logic             auto_nxt;

    // Key bit order matches opcode: {right, left, down, rotate}.
    logic [3:0]          key_lvl, key_d, key_rep, key_ev;
    logic [3:0][CW-1:0]  key_cnt;
    logic                pause_d, pause_ev;

    logic [TW-1:0]    timer, period;
    logic [63:0]      lvl_prod;
    logic             t_exp;
    logic [LCW-1:0]   line_cnt, line_sum;

    assign key_lvl  = {right, left, down, rotate};
    assign pause_ev = pause & ~pause_d;
    assign line_sum = line_cnt + LCW'(lines_cleared);
    assign t_exp    = (TW1'(timer) + TW1'(1)) >= TW1'(period);

    // Key event: rising edge, then first repeat after RPT_DELAY, then every RPT_RATE.
    always_comb begin
        key_ev = '0;
        for (int i = 0; i < 4; i++) begin
            key_ev[i] = key_lvl[i] & (~key_d[i] |
                        (key_rep[i] ? (key_cnt[i] == CW'(RPT_RATE))
                                    : (key_cnt[i] == CW'(RPT_DELAY))));
        end
    end

    // Per-key repeat counters: count cycles since the last event, cleared on release.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            key_d   <= '0;
            key_rep <= '0;
            key_cnt <= '0;
            pause_d <= 1'b0;
        end else begin
            key_d   <= key_lvl;
            pause_d <= pause;
            for (int i = 0; i < 4; i++) begin
                if (!key_lvl[i]) begin
                    key_cnt[i] <= '0;
                    key_rep[i] <= 1'b0;
                end else if (!key_d[i]) begin
                    key_cnt[i] <= CW'(1);
                    key_rep[i] <= 1'b0;
                end else if (key_ev[i]) begin
                    key_cnt[i] <= CW'(1);
                    key_rep[i] <= 1'b1;
                end else begin
                    key_cnt[i] <= key_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Drop period shrinks with level; compared in 64 bits so it can never wrap below the floor.
    always_comb begin
        lvl_prod = 64'(level) * 64'(PERIOD_STEP);
        if (lvl_prod + 64'(MIN_PERIOD) >= 64'(BASE_PERIOD))
            period = TW'(MIN_PERIOD);
        else
            period = TW'(64'(BASE_PERIOD) - lvl_prod);
    end

    // Next-state logic; key events are only consumed in KEEP, all others are lost.
    always_comb begin
        state_nxt  = state;
        opcode_nxt = opcode;
        auto_nxt   = 1'b0;
        case (state)
            S_BLANK:  if (start) state_nxt = S_RANDOM;
            S_RANDOM: state_nxt = S_KEEP;
            S_KEEP: begin
                if (pause_ev) begin
                    state_nxt = S_PAUSE;
                end else if (t_exp) begin
                    state_nxt  = S_DOWN;
                    auto_nxt   = 1'b1;
                    opcode_nxt = 4'b0000;
                end else if (key_ev[1]) begin
                    state_nxt  = S_DOWN;
                    opcode_nxt = 4'b0010;
                end else if (key_ev[2]) begin
                    state_nxt  = S_MOVE;
                    opcode_nxt = 4'b0100;
                end else if (key_ev[3]) begin
                    state_nxt  = S_MOVE;
                    opcode_nxt = 4'b1000;
                end else if (key_ev[0]) begin
                    state_nxt  = S_MOVE;
                    opcode_nxt = 4'b0001;
                end
            end
            S_MOVE:   state_nxt = move_comp ? S_RENEW1 : S_KEEP;
            S_RENEW1: state_nxt = S_KEEP;
            S_DOWN:   state_nxt = down_comp ? S_RENEW1 : S_RENEW2;
            S_RENEW2: state_nxt = S_REMOVE;
            S_REMOVE: if (remove_finish) state_nxt = S_NEW;
            S_NEW:    state_nxt = die ? S_STOP : S_RANDOM;
            S_STOP:   state_nxt = S_BLANK;
            S_PAUSE:  if (pause_ev) state_nxt = S_KEEP;
            default:  state_nxt = S_BLANK;
        endcase
    end

    // State register with strobes registered from the next state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= S_BLANK;
            opcode     <= 4'b0000;
            auto_down  <= 1'b0;
            gen_random <= 1'b0;
            keep       <= 1'b1;
            move       <= 1'b0;
            renew1     <= 1'b0;
            move_down  <= 1'b0;
            renew2     <= 1'b0;
            remove     <= 1'b0;
            new_piece  <= 1'b0;
            stop       <= 1'b0;
            paused     <= 1'b0;
        end else begin
            state      <= state_nxt;
            opcode     <= opcode_nxt;
            auto_down  <= auto_nxt;
            gen_random <= (state_nxt == S_RANDOM);
            keep       <= (state_nxt != S_KEEP);
            move       <= (state_nxt == S_MOVE);
            renew1     <= (state_nxt == S_RENEW1);
            move_down  <= (state_nxt == S_DOWN);
            renew2     <= (state_nxt == S_RENEW2);
            remove     <= (state_nxt == S_REMOVE);
            new_piece  <= (state_nxt == S_NEW);
            stop       <= (state_nxt == S_STOP);
            paused     <= (state_nxt == S_PAUSE);
        end
    end

    // Drop timer: runs only in KEEP, frozen by pause, cleared by any drop.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            timer <= '0;
        end else if (state == S_BLANK && start) begin
            timer <= '0;
        end else if (state == S_KEEP) begin
            if (pause_ev)
                timer <= timer;
            else if (t_exp)
                timer <= '0;
            else
                timer <= timer + TW'(1);
        end else if (state == S_DOWN) begin
            timer <= '0;
        end
    end

    // Line accounting: each LINES_PER_LEVEL lines bumps the level, which saturates.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            line_cnt <= '0;
            level    <= '0;
        end else if (state == S_BLANK && start) begin
            line_cnt <= '0;
            level    <= '0;
        end else if (state == S_REMOVE && remove_finish) begin
            if (line_sum >= LCW'(LINES_PER_LEVEL)) begin
                line_cnt <= line_sum - LCW'(LINES_PER_LEVEL);
                if (level < LW'(MAX_LEVEL))
                    level <= level + LW'(1);
            end else begin
                line_cnt <= line_sum;
            end
        end
    end

endmodule

// File: tb/tb_tetris_ctrl_gen.sv
// tb_tetris_ctrl_gen: vector table through a scoreboard queue, then
// hand sequences for drop timing, key repeat, levels, pause and abort.
module tb_tetris_ctrl_gen;
    localparam int BASE = 100;
    localparam int STEP = 10;
    localparam int MINP = 30;
    localparam int LPL  = 4;
    localparam int MAXL = 15;
    localparam int RD   = 20;
    localparam int RR   = 10;

    // Output vector: {gen_random,keep,move,renew1,move_down,renew2,remove,new,stop,auto_down,paused}
    localparam logic [10:0] S_BLANK  = 11'b01000000000;
    localparam logic [10:0] S_RANDOM = 11'b11000000000;
    localparam logic [10:0] S_KEEP   = 11'b00000000000;
    localparam logic [10:0] S_MOVE   = 11'b01100000000;
    localparam logic [10:0] S_RENEW1 = 11'b01010000000;
    localparam logic [10:0] S_DOWN   = 11'b01001000000;
    localparam logic [10:0] S_RENEW2 = 11'b01000100000;
    localparam logic [10:0] S_REMOVE = 11'b01000010000;
    localparam logic [10:0] S_NEW    = 11'b01000001000;
    localparam logic [10:0] S_STOP   = 11'b01000000100;
    localparam logic [10:0] S_PAUSE  = 11'b01000000001;

    // Input vector: {start,pause,right,left,down,rotate,move_comp,down_comp,remove_finish,lines[2:0],die}
    localparam logic [12:0] NONE = 13'h0000;
    localparam logic [12:0] ST   = 13'h1000;
    localparam logic [12:0] PA   = 13'h0800;
    localparam logic [12:0] KR   = 13'h0400;
    localparam logic [12:0] KL   = 13'h0200;
    localparam logic [12:0] KD   = 13'h0100;
    localparam logic [12:0] KT   = 13'h0080;
    localparam logic [12:0] MC   = 13'h0040;
    localparam logic [12:0] DC   = 13'h0020;
    localparam logic [12:0] RF   = 13'h0010;
    localparam logic [12:0] LC2  = 13'h0004;
    localparam logic [12:0] LC3  = 13'h0006;
    localparam logic [12:0] LC4  = 13'h0008;
    localparam logic [12:0] DIE  = 13'h0001;

    typedef struct packed {
        logic [12:0] in;
        logic [10:0] est;
        logic [3:0]  eop;
        logic [3:0]  elv;
    } vec_t;

    logic clk = 1'b0;
    logic clr;
    logic start, pause, rotate, left, right, down;
    logic move_comp, down_comp, remove_finish, die;
    logic [2:0] lines_cleared;
    logic [3:0] opcode;
    logic gen_random, keep, move, renew1, move_down, renew2, remove, new_piece, stop;
    logic auto_down, paused;
    logic [3:0] level;

    int n_run, n_fail;
    vec_t tbl[$];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    tetris_ctrl_gen #(
        .BASE_PERIOD(BASE), .PERIOD_STEP(STEP), .MIN_PERIOD(MINP),
        .LINES_PER_LEVEL(LPL), .MAX_LEVEL(MAXL), .RPT_DELAY(RD), .RPT_RATE(RR)
    ) dut (
        .clk(clk), .clr(clr), .start(start), .pause(pause),
        .rotate(rotate), .left(left), .right(right), .down(down),
        .move_comp(move_comp), .down_comp(down_comp),
        .remove_finish(remove_finish), .lines_cleared(lines_cleared), .die(die),
        .opcode(opcode), .gen_random(gen_random), .keep(keep), .move(move),
        .renew1(renew1), .move_down(move_down), .renew2(renew2), .remove(remove),
        .new_piece(new_piece), .stop(stop), .auto_down(auto_down),
        .paused(paused), .level(level)
    );

    function automatic logic [10:0] st_now();
        return {gen_random, keep, move, renew1, move_down, renew2, remove,
                new_piece, stop, auto_down, paused};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [12:0] i);
        {start, pause, right, left, down, rotate, move_comp, down_comp,
         remove_finish, lines_cleared, die} = i;
    endtask

    function automatic void add(input logic [12:0] i, input logic [10:0] s,
                                input logic [3:0] o, input logic [3:0] l);
        vec_t v;
        v.in = i; v.est = s; v.eop = o; v.elv = l;
        tbl.push_back(v);
    endfunction

    task automatic do_reset();
        drive(NONE);
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_keep();
        for (int k = 0; k < 500; k++) begin
            if (!keep) return;
            @(negedge clk);
        end
        chk("wait_keep_timeout", {31'd0, keep}, 32'd0);
    endtask

    task automatic wait_remove();
        for (int k = 0; k < 50; k++) begin
            if (remove) return;
            @(negedge clk);
        end
        chk("wait_remove_timeout", {31'd0, remove}, 32'd1);
    endtask

    // Counts KEEP cycles (starting at the current one) until DOWN shows up.
    task automatic measure(output int n);
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            if (move_down) return;
            if (!keep) n++;
            @(negedge clk);
        end
        n = -1;
    endtask

    // One key-initiated drop that lands and clears n lines.
    task automatic round(input logic [2:0] n);
        wait_keep();
        down_comp = 1'b0;
        down = 1'b1;
        @(negedge clk);
        down = 1'b0;
        wait_remove();
        remove_finish = 1'b1;
        lines_cleared = n;
        @(negedge clk);
        remove_finish = 1'b0;
        lines_cleared = 3'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int hits, rem_cnt;
        int offs[4];
        int rexp[4];
        vec_t e;
        n_run = 0;
        n_fail = 0;
        offs = '{-1, -1, -1, -1};
        rexp = '{0, RD, RD + RR, RD + 2 * RR};

        // reset values
        drive(NONE);
        clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", 32'(st_now()), 32'(S_BLANK));
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        clr = 1'b0;

        // FSM walk: input vector -> expected outputs after the next edge
        add(NONE,           S_BLANK,  4'b0000, 4'd0);
        add(ST,             S_RANDOM, 4'b0000, 4'd0);
        add(NONE,           S_KEEP,   4'b0000, 4'd0);
        add(KL,             S_MOVE,   4'b0100, 4'd0);
        add(KL | MC,        S_RENEW1, 4'b0100, 4'd0);
        add(NONE,           S_KEEP,   4'b0100, 4'd0);
        add(KR | KL | KD,   S_DOWN,   4'b0010, 4'd0);
        add(DC,             S_RENEW1, 4'b0010, 4'd0);
        add(NONE,           S_KEEP,   4'b0010, 4'd0);
        add(KR | KT,        S_MOVE,   4'b1000, 4'd0);
        add(NONE,           S_KEEP,   4'b1000, 4'd0);
        add(KT,             S_MOVE,   4'b0001, 4'd0);
        add(KT | KL | MC,   S_RENEW1, 4'b0001, 4'd0);
        add(KT | KL,        S_KEEP,   4'b0001, 4'd0);
        add(KT | KL,        S_KEEP,   4'b0001, 4'd0);
        add(NONE,           S_KEEP,   4'b0001, 4'd0);
        add(KD,             S_DOWN,   4'b0010, 4'd0);
        add(NONE,           S_RENEW2, 4'b0010, 4'd0);
        add(NONE,           S_REMOVE, 4'b0010, 4'd0);
        add(NONE,           S_REMOVE, 4'b0010, 4'd0);
        add(RF | LC3,       S_NEW,    4'b0010, 4'd0);
        add(NONE,           S_RANDOM, 4'b0010, 4'd0);
        add(NONE,           S_KEEP,   4'b0010, 4'd0);
        add(KD,             S_DOWN,   4'b0010, 4'd0);
        add(NONE,           S_RENEW2, 4'b0010, 4'd0);
        add(NONE,           S_REMOVE, 4'b0010, 4'd0);
        add(RF | LC2,       S_NEW,    4'b0010, 4'd1);
        add(DIE,            S_STOP,   4'b0010, 4'd1);
        add(NONE,           S_BLANK,  4'b0010, 4'd1);
        add(NONE,           S_BLANK,  4'b0010, 4'd1);
        add(ST,             S_RANDOM, 4'b0010, 4'd0);
        add(NONE,           S_KEEP,   4'b0010, 4'd0);
        add(PA,             S_PAUSE,  4'b0010, 4'd0);
        add(PA | KL,        S_PAUSE,  4'b0010, 4'd0);
        add(KL,             S_PAUSE,  4'b0010, 4'd0);
        add(PA | KL,        S_KEEP,   4'b0010, 4'd0);
        add(NONE,           S_KEEP,   4'b0010, 4'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in);
            sb_q.push_back(tbl[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_state", i), 32'(st_now()), 32'(e.est));
            chk($sformatf("vec%0d_opcode", i), 32'(opcode), 32'(e.eop));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(e.elv));
        end

        // auto-drop at level 0
        do_reset();
        drive(ST);
        @(negedge clk);
        drive(DC);
        wait_keep();
        measure(n);
        chk("drop_period_l0", 32'(n), 32'(BASE));
        chk("auto_down_set", {31'd0, auto_down}, 32'd1);
        chk("auto_opcode", 32'(opcode), 32'd0);
        @(negedge clk);
        chk("auto_down_pulse", {31'd0, auto_down}, 32'd0);

        // held left: edge, then first repeat after RD, then every RR
        wait_keep();
        move_comp = 1'b1;
        hits = 0;
        for (int i = 0; i < 60; i++) begin
            left = (i < 50);
            @(negedge clk);
            if (move) begin
                if (hits < 4) offs[hits] = i;
                chk("rpt_opcode", 32'(opcode), 32'b0100);
                hits++;
            end
        end
        left = 1'b0;
        move_comp = 1'b0;
        chk("rpt_hits", 32'(hits), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rpt_offset%0d", i), 32'(offs[i]), 32'(rexp[i]));

        // failed drop, five REMOVE cycles, four lines -> level 1
        do_reset();
        drive(ST);
        @(negedge clk);
        drive(NONE);
        wait_keep();
        down = 1'b1;
        @(negedge clk);
        chk("lv_down", 32'(st_now()), 32'(S_DOWN));
        chk("lv_down_op", 32'(opcode), 32'b0010);
        down = 1'b0;
        @(negedge clk);
        chk("lv_renew2", 32'(st_now()), 32'(S_RENEW2));
        @(negedge clk);
        rem_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!remove) break;
            rem_cnt++;
            remove_finish = (rem_cnt == 5);
            lines_cleared = (rem_cnt == 5) ? 3'd4 : 3'd0;
            @(negedge clk);
        end
        remove_finish = 1'b0;
        lines_cleared = 3'd0;
        chk("lv_remove_cycles", 32'(rem_cnt), 32'd5);
        chk("lv_new", 32'(st_now()), 32'(S_NEW));
        chk("lv_level1", 32'(level), 32'd1);
        drive(DC);
        wait_keep();
        measure(n);
        chk("drop_period_l1", 32'(n), 32'(BASE - STEP));

        // more level-ups: 3, then the floor at 7, then saturation
        for (int r = 0; r < 2; r++) round(3'd4);
        chk("level3", 32'(level), 32'd3);
        down_comp = 1'b1;
        wait_keep();
        measure(n);
        chk("drop_period_l3", 32'(n), 32'(BASE - 3 * STEP));
        for (int r = 0; r < 4; r++) round(3'd4);
        chk("level7", 32'(level), 32'd7);
        down_comp = 1'b1;
        wait_keep();
        measure(n);
        chk("drop_period_l7", 32'(n), 32'(MINP));
        for (int r = 0; r < 14; r++) round(3'd4);
        chk("level_sat", 32'(level), 32'(MAXL));
        down_comp = 1'b1;
        wait_keep();
        measure(n);
        chk("drop_period_sat", 32'(n), 32'(MINP));

        // pause at timer 50 for 1000 cycles, then 50 more KEEP cycles to drop
        do_reset();
        drive(ST);
        @(negedge clk);
        drive(NONE);
        wait_keep();
        repeat (50) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        chk("pause_enter", 32'(st_now()), 32'(S_PAUSE));
        pause = 1'b0;
        repeat (1000) @(negedge clk);
        chk("pause_hold", 32'(st_now()), 32'(S_PAUSE));
        pause = 1'b1;
        @(negedge clk);
        chk("pause_exit", 32'(st_now()), 32'(S_KEEP));
        pause = 1'b0;
        down_comp = 1'b1;
        measure(n);
        chk("pause_drop", 32'(n), 32'd50);

        // clr during REMOVE aborts to BLANK with level cleared
        round(3'd4);
        chk("abort_pre_level", 32'(level), 32'd1);
        wait_keep();
        down_comp = 1'b0;
        down = 1'b1;
        @(negedge clk);
        down = 1'b0;
        wait_remove();
        #2 clr = 1'b1;
        #1;
        chk("abort_state", 32'(st_now()), 32'(S_BLANK));
        chk("abort_level", 32'(level), 32'd0);
        chk("abort_opcode", 32'(opcode), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        drive(NONE);
        repeat (3) @(negedge clk);
        chk("abort_idle", 32'(st_now()), 32'(S_BLANK));
        drive(ST);
        @(negedge clk);
        chk("abort_restart", 32'(st_now()), 32'(S_RANDOM));
        drive(NONE);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
